// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use stalls, mul/div scoreboard,
// branch flushes and a saturating count of fetch-stall cycles.
module hazard_ctrl_unit #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned AW         = 5,
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC*AW-1:0]   id_rs_addr,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    input  logic [NUM_SRC*AW-1:0]   id_ex_rs_addr,
    input  logic [AW-1:0]           id_ex_rd_addr,
    input  logic                    id_ex_memread,
    input  logic [AW-1:0]           ex_mem_rd_addr,
    input  logic                    ex_mem_regwrite,
    input  logic [AW-1:0]           mem_wb_rd_addr,
    input  logic                    mem_wb_regwrite,
    input  logic                    ex_branch_taken,
    input  logic                    mc_issue,
    input  logic [AW-1:0]           mc_issue_rd,
    input  logic                    mc_done,
    input  logic [AW-1:0]           mc_done_rd,
    output logic [2*NUM_SRC-1:0]    forward_sel,
    output logic                    stall_fetch,
    output logic                    bubble_ex,
    output logic                    flush_if_id,
    output logic [31:0]             stall_cycles
);

    localparam int unsigned CW   = $clog2(LOAD_STALL + 1);
    localparam int unsigned NREG = 2 ** AW;

    logic [CW-1:0]      lu_cnt_q, lu_cnt_d;
    // Bit 0 is kept constant zero so any address can index without a range guard.
    logic [NREG-1:0]    busy_q, busy_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;

    logic [NUM_SRC-1:0] lu_hit;
    logic [NUM_SRC-1:0] sb_hit;
    logic               lu;
    logic               sb;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [AW-1:0] id_rs;
        logic [AW-1:0] ex_rs;
        logic          live;
        logic          fwd_mem;
        logic          fwd_wb;

        assign id_rs = id_rs_addr[g*AW +: AW];
        assign ex_rs = id_ex_rs_addr[g*AW +: AW];
        assign live  = id_rs_used[g] && (id_rs != '0);

        assign lu_hit[g] = live && (id_rs == id_ex_rd_addr);
        // No bypass from mc_done: the bit still reads busy in its clearing cycle.
        assign sb_hit[g] = live && busy_q[id_rs];

        assign fwd_mem = ex_mem_regwrite && (ex_mem_rd_addr != '0) && (ex_mem_rd_addr == ex_rs);
        assign fwd_wb  = mem_wb_regwrite && (mem_wb_rd_addr != '0) && (mem_wb_rd_addr == ex_rs);
        assign forward_sel[2*g +: 2] = fwd_mem ? 2'b10 : (fwd_wb ? 2'b01 : 2'b00);
    end

    assign lu = id_ex_memread && (id_ex_rd_addr != '0) && (|lu_hit);
    assign sb = |sb_hit;

    always_comb begin
        stall_fetch    = 1'b0;
        bubble_ex      = 1'b0;
        flush_if_id    = 1'b0;
        lu_cnt_d       = lu_cnt_q;
        busy_d         = busy_q;
        stall_cycles_d = stall_cycles_q;

        if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
            lu_cnt_d    = '0;
        end else begin
            if (lu || (lu_cnt_q != '0) || sb) begin
                stall_fetch = 1'b1;
                bubble_ex   = 1'b1;
            end
            // The first stall cycle is the detect cycle itself, hence LOAD_STALL-1.
            if (lu_cnt_q != '0) begin
                lu_cnt_d = lu_cnt_q - CW'(1);
            end else if (lu) begin
                lu_cnt_d = CW'(LOAD_STALL - 1);
            end
        end

        if (mc_done && (mc_done_rd != '0)) begin
            busy_d[mc_done_rd] = 1'b0;
        end
        if (mc_issue && (mc_issue_rd != '0)) begin
            busy_d[mc_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (stall_fetch && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q       <= '0;
            busy_q         <= '0;
            stall_cycles_q <= '0;
        end else begin
            lu_cnt_q       <= lu_cnt_d;
            busy_q         <= busy_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage RISC-V core: the successor to the two-source combinational forwarding unit. It keeps forwarding selection for a parametrised number of EX source operands and adds several hazard functions. These are load-use stalls of configurable length, branch-taken flushes, a register scoreboard for the multi-cycle (mul/div) unit, and a saturating stall-cycle counter. It sits beside the decode stage and drives the PC/IF-ID enables, the pipeline-register bubble/flush controls and the EX operand muxes.

## Interface
Parameters:
- NUM_SRC, 2: source operands per instruction (rs1, rs2, optionally rs3).
- AW, 5: register address width; register file has 2**AW entries, entry 0 hard-wired zero.
- LOAD_STALL, 1: bubbles inserted per load-use hazard, ≥1.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low.
- id_rs_addr  in  NUM_SRC*AW  source addresses of the instruction in ID; source i at [i*AW +: AW].
- id_rs_used  in  NUM_SRC  bit i set when ID instruction actually reads source i.
- id_ex_rs_addr  in  NUM_SRC*AW  source addresses of the instruction in EX.
- id_ex_rd_addr  in  AW  destination of the instruction in EX.
- id_ex_memread  in  1  instruction in EX is a load.
- ex_mem_rd_addr  in  AW  destination in MEM.
- ex_mem_regwrite  in  1  MEM instruction writes rd.
- mem_wb_rd_addr  in  AW  destination in WB.
- mem_wb_regwrite  in  1  WB instruction writes rd.
- ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle.
- mc_issue  in  1  multi-cycle op issued this cycle.
- mc_issue_rd  in  AW  its destination.
- mc_done  in  1  multi-cycle result written back this cycle.
- mc_done_rd  in  AW  its destination.
- forward_sel  out  2*NUM_SRC  per source i at [2*i +: 2]: 00 register file, 10 EX/MEM, 01 MEM/WB.
- stall_fetch  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  load NOP into IF/ID.
- stall_cycles  out  32  cycles with stall_fetch=1 since reset, saturating.

## Operation
- Forwarding is combinational, per source i.
  - 10 if ex_mem_regwrite, ex_mem_rd≠0 and ex_mem_rd==id_ex_rs[i].
  - Otherwise 01 if the same conditions hold for MEM/WB.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- A source of the ID instruction counts as live when id_rs_used[i]=1 and id_rs[i]≠0.
- Load-use detect (LU): id_ex_memread, id_ex_rd≠0, and id_ex_rd equals any live ID source.
- Load-use counter lu_cnt, width $clog2(LOAD_STALL+1):
  - loads LOAD_STALL-1 when LU=1 and lu_cnt=0;
  - decrements while nonzero;
  - never reloads while nonzero.
- Scoreboard busy[2**AW-1:1]:
  - mc_issue with rd≠0 sets busy[rd];
  - mc_done with rd≠0 clears busy[rd];
  - issue and done to the same rd in the same cycle leaves the bit set;
  - rd=0 is ignored for both.
- Scoreboard hazard (SB): any live ID source has busy=1. A source being cleared by mc_done this cycle still counts as busy (no bypass).
- Stall: when LU, lu_cnt≠0 or SB, drive stall_fetch=1, bubble_ex=1, flush_if_id=0.
- Flush: ex_branch_taken overrides every stall.
  - Outputs: flush_if_id=1, bubble_ex=1, stall_fetch=0.
  - lu_cnt is cleared next edge.
  - Scoreboard is not affected (the issued op already left ID).
- Idle: all three controls 0.
- stall_cycles increments on every edge where stall_fetch=1 and holds at 0xFFFF_FFFF.

## Timing
- forward_sel, stall_fetch, bubble_ex and flush_if_id are combinational from inputs and state, with zero latency.
- A load-use hazard seen in cycle T stalls cycles T .. T+LOAD_STALL-1 (exactly LOAD_STALL cycles).
- After mc_issue at edge E, busy is visible from cycle E+1. It clears on the edge where mc_done is sampled, so the consumer proceeds the following cycle.
- Reset (rst_n=0, any time) asynchronously clears busy, lu_cnt and stall_cycles.
  - With all inputs 0, every output is 0.
  - A reset in mid-stall ends the stall immediately.
- No state changes occur while rst_n=0.

## Test plan
- Forwarding priority: EX/MEM rd=5 and MEM/WB rd=5, both regwrite, id_ex_rs1=5 → forward_sel[1:0]=10. Same case with rd=0 → 00.
- Load-use, LOAD_STALL=3: load rd=7 in EX with ID rs2=7 used → stall_fetch and bubble_ex high for exactly 3 cycles, then low; stall_cycles=3.
- Unused or zero source: same load with id_rs_used[1]=0, or load rd=0 → no stall.
- Scoreboard: mc_issue rd=9; next cycle ID rs1=9 → stall until mc_done rd=9, released the cycle after. Simultaneous issue and done of rd=9 → busy remains 1.
- Branch during stall: ex_branch_taken in the second cycle of a LOAD_STALL=3 stall → flush_if_id=1, bubble_ex=1, stall_fetch=0; the next cycle shows no stall.
- Reset mid-operation: assert rst_n=0 with busy[4]=1, lu_cnt=2, stall_cycles=10 → all cleared asynchronously, outputs 0. Separately, force stall_cycles saturation → holds 0xFFFF_FFFF.
